// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family: FSM state type and
// default sizing constants.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH     = 4;
  localparam int DEFAULT_MAX_VALUE = 8;

endpackage : counter_pkg

// File: rtl/down_counter_props.sv
// Bindable property checker for down_counter: output exclusivity, range of
// count, and single-cycle done outside auto-reload mode.
module down_counter_props #(
  parameter int WIDTH       = 4,
  parameter int MAX_VALUE   = 8,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input logic             clk,
  input logic             reset_n,
  input logic [WIDTH-1:0] count,
  input logic             busy,
  input logic             done
);

  // busy and done are mutually exclusive at every edge.
  a_busy_done_excl : assert property (@(posedge clk) disable iff (!reset_n)
    !(busy && done));

  // The count never exceeds the saturation limit.
  a_count_range : assert property (@(posedge clk) disable iff (!reset_n)
    (32'(count) <= MAX_VALUE));

  // done is always accompanied by a zero count.
  a_done_zero : assert property (@(posedge clk) disable iff (!reset_n)
    done |-> (count == '0));

  generate
    if (!AUTO_RELOAD) begin : g_one_shot
      // Without reload, done never lasts two consecutive cycles.
      a_done_pulse : assert property (@(posedge clk) disable iff (!reset_n)
        done |=> !done);
    end
  endgenerate

endmodule : down_counter_props

// File: rtl/down_counter.sv
// Loadable down-counting timer. A start in IDLE captures a saturated load
// value, RUN decrements under enable, DONE emits a one-cycle expiry pulse
// and either returns to IDLE or reloads for periodic operation.
module down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int MAX_VALUE   = DEFAULT_MAX_VALUE,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] load_sat_d;

  // Clamp the requested load to the largest accepted terminal value.
  always_comb begin
    load_sat_d = load_value;
    if (load_value > MAX_L) begin
      load_sat_d = MAX_L;
    end
  end

  // Single FSM with registered outputs; abort takes priority over any
  // decrement or expiry in RUN and over reload in DONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            count_q  <= load_sat_d;
            reload_q <= load_sat_d;
            if (load_sat_d != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
          end else if (enable) begin
            if (count_q == ONE) begin
              state_q <= DONE;
              count_q <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              count_q <= count_q - ONE;
            end
          end
        end

        DONE: begin
          if (abort || !AUTO_RELOAD) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
          end else begin
            count_q <= reload_q;
            if (reload_q != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              // Zero reload value: stay in DONE with done held high.
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          count_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule : down_counter
